// File: rtl/seq_detect_prog_if.sv
// seq_detect_prog_if
//   Bundles the serial input, configuration and result signals of
//   seq_detect_prog. The bench or upstream logic uses the master modport.
//   The detector uses the slave modport.
//   clk and reset are not part of the bundle.
//   Signals:
//     x, x_valid          serial bit and its qualifier
//     cfg_load            one-cycle strobe that loads cfg_pattern/cfg_len/cfg_overlap
//     cfg_pattern         pattern, bit [len-1] received first
//     cfg_len             pattern length (1..MAX_LEN accepted)
//     cfg_overlap         1 = overlapping detection
//     count_clr           synchronous clear of match_count
//     z                   registered one-cycle match pulse
//     match_count         saturating match counter
//     cfg_err             one-cycle pulse when a load is rejected
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  modport master (
    output x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
    input  z, match_count, cfg_err
  );

  modport slave (
    input  x, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
    output z, match_count, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// seq_detect_prog
//   Runtime-programmable serial pattern detector.
//   It detects a pattern of 1..MAX_LEN bits.
//   Overlapping or non-overlapping detection is selectable at run time.
//   Outputs are a registered match pulse and a saturating match counter.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears all state and restores the
//            default configuration
//     bus    seq_detect_prog_if.slave; serial input, config load, results
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1010,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  seq_detect_prog_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Mask selecting the low l bits of a pattern-wide word.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(l));
    end
    return m;
  endfunction

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic               z_r;
  logic               err_r;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               cfg_ok;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  // Combinational evaluation of the bit presented this cycle
  always_comb begin
    // A load in the same cycle owns the cycle; the serial bit is dropped.
    accept = bus.x_valid & ~bus.cfg_load;
    cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
    hist_n = {hist[MAX_LEN-2:0], bus.x};
    fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    mask   = len_mask(len);
    match  = accept && (fill_n >= len) && ((hist_n & mask) == (pat & mask));
  end

  // Register stage: history, config, pulses and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= DEF_PATTERN;
      len   <= LEN_W'(DEF_LEN);
      ovl   <= DEF_OVERLAP;
      z_r   <= 1'b0;
      err_r <= 1'b0;
      cnt   <= '0;
    end else begin
      z_r   <= match;
      err_r <= bus.cfg_load & ~cfg_ok;
      if (bus.cfg_load) begin
        // A rejected load leaves both config and history untouched.
        if (cfg_ok) begin
          pat  <= bus.cfg_pattern;
          len  <= bus.cfg_len;
          ovl  <= bus.cfg_overlap;
          hist <= '0;
          fill <= '0;
        end
      end else if (accept) begin
        hist <= hist_n;
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        fill <= (match && !ovl) ? '0 : fill_n;
      end
      if (bus.count_clr) begin
        cnt <= '0;
      end else if (match) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  assign bus.z           = z_r;
  assign bus.cfg_err     = err_r;
  assign bus.match_count = cnt;
endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised successor to the team's fixed 1010 Mealy detector.
- Detects a runtime-programmable serial bit pattern of length 1..MAX_LEN on a qualified serial input.
- Overlap or non-overlap detection is selectable at run time.
- Provides a registered match pulse and a saturating match counter; sits on serial-protocol front ends (frame-sync / preamble detection).

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- DEF_PATTERN, 8'b0000_1010, pattern after reset (low DEF_LEN bits used).
- DEF_LEN, 4, pattern length after reset (1..MAX_LEN).
- DEF_OVERLAP, 0, overlap mode after reset (0 = non-overlap).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only in cycles where this is 1.
- cfg_load  in  1  one-cycle strobe; loads cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping detection.
- count_clr  in  1  synchronous clear of match_count.
- z  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating number of matches.
- cfg_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high) values:
  - z=0, match_count=0, cfg_err=0.
  - History register and fill count = 0.
  - Active config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
- State:
  - hist[MAX_LEN-1:0] shift register, newest bit at hist[0].
  - fill counter 0..MAX_LEN (saturating) of valid bits held.
- On an accepted bit (x_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], x}; fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n >= len) and (hist_n[len-1:0] == pattern[len-1:0]).
- Latency: z=1 in the cycle after the clock edge that samples the completing bit, for exactly one cycle. z=0 in every cycle without a match, including x_valid=0 cycles.
- Mode behaviour on match:
  - Non-overlap: fill <= 0, so the next match needs len fresh bits.
  - Overlap: fill stays at fill_n, so a suffix of the matched bits may begin the next match.
- x_valid=0: hist, fill and z hold off (z=0); no state advance.
- cfg_load:
  - Valid only if 1 <= cfg_len <= MAX_LEN. If valid: config latched, hist and fill cleared.
  - If cfg_len is invalid: config unchanged, history unchanged, cfg_err=1 next cycle.
- Simultaneous cfg_load and x_valid: load takes priority; the bit is discarded and not counted.
- match_count: +1 per match, saturates at 2^CNT_W-1.
- Simultaneous count_clr and match: clear wins, count=0.
- len=1: every accepted bit equal to pattern[0] is a match in both modes.
- Reset mid-stream: all outputs drop immediately (asynchronously), and the default config is restored.

Test Plan:
- Default config (1010, len 4, non-overlap), bits 1,0,1,0,1,0 on consecutive valid cycles -> z pulses once, one cycle after the 4th bit; match_count=1.
- Load cfg_pattern=1010, cfg_len=4, cfg_overlap=1, same stream -> z pulses after bits 4 and 6; match_count=2.
- Default config, bits 1,0,1,0 with x_valid=0 gap cycles interleaved -> single z pulse after the last valid bit; no pulse in gap cycles.
- Load cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; the default 1010 still detects.
- CNT_W=2, overlap, pattern 1 with len 1, five valid 1s -> match_count 1,2,3,3,3.
- Assert count_clr on the same cycle a match registers -> match_count=0.
- Assert reset between bits 3 and 4 of 1010 -> no z; detection resumes only after 4 new bits.
